// File: rtl/logic_eval_pipe_pkg.sv
// Shared definitions for the logic_eval_pipe block: function-select encoding
// and default widths.
package logic_eval_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_AND_OR  = 2'd0,
        MODE_OR_ANDN = 2'd1,
        MODE_XOR3    = 2'd2,
        MODE_AND3    = 2'd3
    } mode_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/logic_eval_pipe_fn.sv
// Combinational bitwise evaluator: selected function of a/b/c on d, ~c on e.
module logic_eval_pipe_fn
    import logic_eval_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  mode_e            mode,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e
);

    always_comb begin
        d = '0;
        unique case (mode)
            MODE_AND_OR:  d = (a & b) | ~c;
            MODE_OR_ANDN: d = (a | b) & ~c;
            MODE_XOR3:    d = a ^ b ^ c;
            MODE_AND3:    d = a & b & c;
            default:      d = '0;
        endcase
    end

    assign e = ~c;

endmodule

// File: rtl/logic_eval_pipe.sv
// Two-stage pipelined bitwise evaluator with valid qualification, per-bit
// rising-edge detection on d and a saturating count of non-zero beats.
module logic_eval_pipe
    import logic_eval_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] d_rise,
    output logic [CNT_W-1:0] hit_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [WIDTH-1:0] c_p1;
    mode_e            mode_p1;
    logic             vld_p1;

    logic [WIDTH-1:0] d_fn;
    logic [WIDTH-1:0] e_fn;

    logic [WIDTH-1:0] d_p2;
    logic [WIDTH-1:0] e_p2;
    logic [WIDTH-1:0] d_rise_p2;
    logic [WIDTH-1:0] d_prev;
    logic             vld_p2;
    logic [CNT_W-1:0] hit_cnt_p2;

    // ---- stage 1: capture operands every cycle, valid travels alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            a_p1    <= '0;
            b_p1    <= '0;
            c_p1    <= '0;
            mode_p1 <= MODE_AND_OR;
            vld_p1  <= 1'b0;
        end else begin
            a_p1    <= a;
            b_p1    <= b;
            c_p1    <= c;
            mode_p1 <= mode_e'(mode);
            vld_p1  <= in_valid;
        end
    end

    logic_eval_pipe_fn #(
        .WIDTH (WIDTH)
    ) u_fn (
        .a    (a_p1),
        .b    (b_p1),
        .c    (c_p1),
        .mode (mode_p1),
        .d    (d_fn),
        .e    (e_fn)
    );

    // ---- stage 2: result registers, edge detect and hit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            d_p2      <= '0;
            e_p2      <= '0;
            d_rise_p2 <= '0;
            d_prev    <= '0;
            vld_p2    <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                d_p2      <= d_fn;
                e_p2      <= e_fn;
                d_rise_p2 <= d_fn & ~d_prev;
                d_prev    <= d_fn;
            end else begin
                d_rise_p2 <= '0;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            hit_cnt_p2 <= '0;
        end else if (vld_p1 && (|d_fn)) begin
            hit_cnt_p2 <= sat_inc(hit_cnt_p2);
        end
    end

    assign out_valid = vld_p2;
    assign d         = d_p2;
    assign e         = e_p2;
    assign d_rise    = d_rise_p2;
    assign hit_cnt   = hit_cnt_p2;

endmodule
